spi_master_param: RTL and testbench

Parametrised, full-duplex SPI master; the next-generation replacement for the team's fixed 8-bit, mode-0, single-slave transmitter. It accepts one word per valid/ready handshake and drives SCLK/MOSI/CS_n for one of several slaves with per-transaction CPOL/CPHA. It returns the simultaneously sampled MISO word with a one-cycle strobe. It sits between a register/DMA front end and the SPI pads.

---
 rtl/spi_master_param.sv | 185 ++++++++++++++++++
 tb/tb_spi_master_param.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised full-duplex SPI master, per-transfer CPOL/CPHA and chip select
// Optional feature macro: SPI_MASTER_LSB_FIRST_EN adds the lsb_first input (LSB-first shifting).
module spi_master_param #(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 4,
  parameter int NUM_CS   = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  localparam int CSW     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CSW-1:0]    cs_sel,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                                                : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int EDGES   = 2 * DATA_W;
  localparam int EDGE_W  = $clog2(EDGES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_HOLD} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              rx_valid_q, rx_valid_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;

  logic              lsb_in;
  logic [EDGE_W-1:0] edge_num;
  logic              leading, last_edge, sample, advance;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  // Out-of-range selects decode to no active line; the transfer still runs.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CSW-1:0] sel);
    logic [NUM_CS-1:0] v;
    for (int i = 0; i < NUM_CS; i++) v[i] = (int'(sel) != i);
    return v;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rx_valid_d = 1'b0;
    edge_num   = edge_q + EDGE_W'(1);
    leading    = edge_num[0];
    last_edge  = (edge_num == EDGE_W'(EDGES));
    sample     = (leading != cpha_q);
    advance    = !sample && !(cpha_q ? (edge_num == EDGE_W'(1)) : last_edge);

    case (state_q)
      ST_IDLE: begin
        sclk_d = cpol;
        mosi_d = 1'b0;
        cs_n_d = '1;
        if (tx_valid && tx_ready) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          edge_d  = '0;
          tx_sh_d = tx_data;
          rx_sh_d = '0;
          cpha_d  = cpha;
          lsb_d   = lsb_in;
          mosi_d  = lsb_in ? tx_data[0] : tx_data[DATA_W-1];
          cs_n_d  = cs_decode(cs_sel);
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          state_d = ST_XFER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_XFER: begin
        // Each SCLK edge lands at the end of a CLK_DIV-cycle half period.
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d  = '0;
          sclk_d = !sclk_q;
          edge_d = edge_num;
          if (sample) begin
            rx_sh_d = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso};
          end
          if (advance) begin
            tx_sh_d = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
            mosi_d  = lsb_q ? tx_sh_q[1] : tx_sh_q[DATA_W-2];
          end
          if (last_edge) state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          cs_n_d     = '1;
          mosi_d     = 1'b0;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      cs_n_q     <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign tx_ready = (state_q == ST_IDLE) && !rst;
  assign busy     = (state_q != ST_IDLE);
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - randomized self-checking bench for spi_master_param
// Behavioural SPI slave (cs window, edge counting, mode-driven shift/sample) provides reference data.
module tb_spi_master_param;

  localparam int DATA_W   = 8;
  localparam int CLK_DIV  = 2;
  localparam int NUM_CS   = 3;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CSW      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int LAT      = CS_SETUP + 2 * DATA_W * CLK_DIV + CS_HOLD;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data = '0;
  logic [CSW-1:0]    cs_sel = '0;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic              lsb_first_v = 1'b0;
`endif
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              busy, sclk, mosi, miso;
  logic [NUM_CS-1:0] cs_n;

  int n_tests = 0;
  int n_fail  = 0;

  spi_master_param #(
    .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .NUM_CS(NUM_CS),
    .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb_first_v),
`endif
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .sclk(sclk),
    .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  // Slave: presents bits MSB-first from slv_word, captures mosi MSB-first.
  logic [DATA_W-1:0] slv_word = '0;
  logic [DATA_W-1:0] slv_rx = '0;
  logic              slv_pha = 1'b0;
  logic              slv_bit = 1'b0;
  logic              loop_en = 1'b0;
  logic              prev_busy = 1'b0;
  logic              prev_sclk = 1'b0;
  int                slv_k = 0;
  int                slv_edges = 0;

  assign miso = loop_en ? mosi : slv_bit;

  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      slv_edges = 0;
      slv_rx    = '0;
      slv_k     = 0;
      if (!slv_pha) begin
        slv_bit = slv_word[DATA_W-1];
        slv_k   = 1;
      end
    end else if (busy && (sclk != prev_sclk)) begin
      slv_edges++;
      if (((slv_edges % 2) == 1) != slv_pha) begin
        slv_rx = {slv_rx[DATA_W-2:0], mosi};
      end else if (slv_k < DATA_W) begin
        slv_bit = slv_word[DATA_W-1-slv_k];
        slv_k++;
      end
    end
    prev_busy = busy;
    prev_sclk = sclk;
  end

  task automatic run_xfer(input logic [DATA_W-1:0] data, input int sel, input logic pol,
                          input logic pha, input logic lsb, input logic [DATA_W-1:0] word,
                          input logic loop, input string tag);
    logic [NUM_CS-1:0] exp_pat, all_hi;
    logic [DATA_W-1:0] exp_rx;
    logic              prev;
    int waited, cs_ok, edges, last_e, rxv_at, rxv_cnt;
    all_hi  = '1;
    exp_pat = '1;
    if (sel < NUM_CS) exp_pat[sel] = 1'b0;
    exp_rx  = loop ? data : (lsb ? rev(word) : word);
    slv_word = word;
    slv_pha  = pha;
    loop_en  = loop;
    @(negedge clk);
    waited = 0;
    while (!tx_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      check({tag, "_ready_wait"}, 0, 1);
      return;
    end
    tx_data = data; cs_sel = sel[CSW-1:0]; cpol = pol; cpha = pha; tx_valid = 1'b1;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_first_v = lsb;
`endif
    cs_ok = 0; edges = 0; last_e = -1; rxv_at = -1; rxv_cnt = 0; prev = 1'b0;
    for (int j = 0; j <= LAT + 2; j++) begin
      @(negedge clk);
      if (j == 0) begin
        tx_valid = 1'b0;
        tx_data  = ~data;
        cs_sel   = cs_sel + 1'b1;
        cpha     = ~pha;
        check({tag, "_setup_sclk"}, 32'(sclk), 32'(pol));
        check({tag, "_setup_mosi"}, 32'(mosi), 32'(lsb ? data[0] : data[DATA_W-1]));
      end
      if (j == 1) cpol = ~pol;
      if (j < LAT && cs_n == exp_pat) cs_ok++;
      if (j > 0 && j <= LAT && sclk != prev) begin
        edges++;
        last_e = j;
      end
      prev = sclk;
      if (rx_valid) begin
        rxv_cnt++;
        if (rxv_at < 0) rxv_at = j;
      end
      if (j == LAT) begin
        check({tag, "_end_cs_n"}, 32'(cs_n), 32'(all_hi));
        check({tag, "_end_mosi"}, 32'(mosi), 0);
        check({tag, "_end_sclk"}, 32'(sclk), 32'(pol));
        check({tag, "_end_ready"}, 32'(tx_ready), 1);
        check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_rx));
      end
    end
    check({tag, "_cs_cycles"}, cs_ok, LAT);
    check({tag, "_sclk_edges"}, edges, 2 * DATA_W);
    check({tag, "_cs_hold"}, LAT - last_e, CS_HOLD);
    check({tag, "_rxv_at"}, rxv_at, LAT);
    check({tag, "_rxv_cnt"}, rxv_cnt, 1);
    check({tag, "_slv_edges"}, slv_edges, 2 * DATA_W);
    check({tag, "_slv_rx"}, 32'(slv_rx), 32'(lsb ? rev(data) : data));
  endtask

  initial begin
    logic [NUM_CS-1:0] all_hi;
    int rxv_t[$];
    logic [DATA_W-1:0] rxv_d[$];
    int cs1_hi, cs0_lo, cnt;
    all_hi = '1;

    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'(all_hi));
    check("rst_sclk", 32'(sclk), 0);
    check("rst_mosi", 32'(mosi), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(tx_ready), 1);

    run_xfer(8'hA5, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "mode0_loop");
    run_xfer(8'h3C, 0, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, "mode1");
    run_xfer(8'h3C, 1, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, "mode2");
    run_xfer(8'h3C, 2, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, "mode3");

    // Back-to-back with tx_valid held high.
    slv_pha = 1'b0; loop_en = 1'b1;
    @(negedge clk);
    tx_data = 8'h01; cs_sel = CSW'(1); cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b1;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_first_v = 1'b0;
`endif
    cs1_hi = 0; cs0_lo = 0;
    for (int j = 0; j <= 2 * LAT + 3; j++) begin
      @(negedge clk);
      if (j == 0) tx_data = 8'hFE;
      if (j == LAT + 1) tx_valid = 1'b0;
      if (j <= 2 * LAT && cs_n[1]) cs1_hi++;
      if (!cs_n[0]) cs0_lo++;
      if (rx_valid) begin
        rxv_t.push_back(j);
        rxv_d.push_back(rx_data);
      end
    end
    check("b2b_rxv_count", rxv_t.size(), 2);
    if (rxv_t.size() == 2) begin
      check("b2b_rxv0_at", rxv_t[0], LAT);
      check("b2b_rxv1_at", rxv_t[1], 2 * LAT + 1);
      check("b2b_rx0", 32'(rxv_d[0]), 32'h01);
      check("b2b_rx1", 32'(rxv_d[1]), 32'hFE);
    end
    check("b2b_cs1_gap", cs1_hi, 1);
    check("b2b_cs0_idle", cs0_lo, 0);

    run_xfer(8'h96, 3, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, "cs_oor");

    // Reset during XFER around bit 4.
    loop_en = 1'b1; slv_pha = 1'b0;
    @(negedge clk);
    tx_data = 8'hA5; cs_sel = '0; cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (CS_SETUP + 8 * CLK_DIV) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs_n", 32'(cs_n), 32'(all_hi));
    check("midrst_sclk", 32'(sclk), 0);
    check("midrst_rx_valid", 32'(rx_valid), 0);
    check("midrst_rx_data", 32'(rx_data), 0);
    check("midrst_busy", 32'(busy), 0);
    rst = 1'b0;
    cnt = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (rx_valid) cnt++;
    end
    check("midrst_no_rxv", cnt, 0);
    run_xfer(8'h55, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "after_rst");

    // Reset and request in the same cycle: nothing accepted.
    @(negedge clk);
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h77; cs_sel = '0;
    @(negedge clk);
    check("rstvld_busy", 32'(busy), 0);
    check("rstvld_cs_n", 32'(cs_n), 32'(all_hi));
    tx_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rstvld_busy_after", 32'(busy), 0);

`ifdef SPI_MASTER_LSB_FIRST_EN
    run_xfer(8'h01, 0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, "lsb_loop");
    run_xfer(8'h0D, 1, 1'b1, 1'b1, 1'b1, 8'hB2, 1'b0, "lsb_slave");
`endif

    for (int t = 0; t < 20; t++) begin
      logic lsb_r;
`ifdef SPI_MASTER_LSB_FIRST_EN
      lsb_r = 1'($urandom_range(0, 1));
`else
      lsb_r = 1'b0;
`endif
      run_xfer(DATA_W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), lsb_r, DATA_W'($urandom),
               1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
